wb_regfile: RTL and testbench

- Writeback-end consumer of the MEM/WB pipeline register.
- Selects the writeback result from the W-stage fields and commits it to a 32-entry integer register file.
- Provides two decode-stage read ports with same-cycle write-through bypass, plus a 64-bit retired-instruction counter.
- Sits between the MEM/WB register and the decode stage; the hazard unit reads its result output for forwarding.

---
 rtl/wb_regfile.sv | 79 +++++++
 tb/tb_wb_regfile.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// Writeback stage: result select, 32-entry integer register file with
// write-through read bypass, and a retired-instruction counter.
module wb_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int CNT_WIDTH  = 64,
  localparam int IDX_W     = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  regWrite_w,
  input  logic [1:0]            resultSrc_w,
  input  logic [DATA_WIDTH-1:0] aluResult_w,
  input  logic [DATA_WIDTH-1:0] readData_w,
  input  logic [DATA_WIDTH-1:0] pcPlus4_w,
  input  logic [IDX_W-1:0]      destinationReg_w,
  input  logic                  retire_w,
  input  logic [IDX_W-1:0]      rs1_d,
  input  logic [IDX_W-1:0]      rs2_d,
  output logic [DATA_WIDTH-1:0] rd1_d,
  output logic [DATA_WIDTH-1:0] rd2_d,
  output logic [DATA_WIDTH-1:0] result_w,
  output logic [CNT_WIDTH-1:0]  instret
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  always_comb begin
    result_w = '0;
    case (resultSrc_w)
      2'b00:   result_w = aluResult_w;
      2'b01:   result_w = readData_w;
      2'b10:   result_w = pcPlus4_w;
      default: result_w = '0;
    endcase
  end

  assign wr_en = regWrite_w && (destinationReg_w != '0);

  // Entry 0 is held at zero forever and never read, so it folds away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[destinationReg_w] <= result_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instret <= '0;
    end else if (retire_w) begin
      instret <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Same-cycle write is forwarded so decode never sees a stale entry.
  always_comb begin
    rd1_d = regs[rs1_d];
    if (rs1_d == '0) begin
      rd1_d = '0;
    end else if (regWrite_w && (rs1_d == destinationReg_w)) begin
      rd1_d = result_w;
    end
  end

  always_comb begin
    rd2_d = regs[rs2_d];
    if (rs2_d == '0) begin
      rd2_d = '0;
    end else if (regWrite_w && (rs2_d == destinationReg_w)) begin
      rd2_d = result_w;
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: behavioural register-file/counter model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        regWrite_w;
  logic [1:0]  resultSrc_w;
  logic [31:0] aluResult_w, readData_w, pcPlus4_w;
  logic [4:0]  destinationReg_w;
  logic        retire_w;
  logic [4:0]  rs1_d, rs2_d;
  logic [31:0] rd1_d, rd2_d, result_w;
  logic [63:0] instret;
  logic [31:0] rd1_s, rd2_s, result_s;
  logic [3:0]  instret_s;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .regWrite_w(regWrite_w), .resultSrc_w(resultSrc_w),
    .aluResult_w(aluResult_w), .readData_w(readData_w), .pcPlus4_w(pcPlus4_w),
    .destinationReg_w(destinationReg_w), .retire_w(retire_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .result_w(result_w), .instret(instret)
  );

  // Narrow-counter copy so the wrap from all-ones to zero is reachable.
  wb_regfile #(.CNT_WIDTH(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .regWrite_w(regWrite_w), .resultSrc_w(resultSrc_w),
    .aluResult_w(aluResult_w), .readData_w(readData_w), .pcPlus4_w(pcPlus4_w),
    .destinationReg_w(destinationReg_w), .retire_w(retire_w),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd1_d(rd1_s), .rd2_d(rd2_s),
    .result_w(result_s), .instret(instret_s)
  );

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [31:0] mregs [32];
  logic [63:0] mcnt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_result();
    case (resultSrc_w)
      2'b00:   return aluResult_w;
      2'b01:   return readData_w;
      2'b10:   return pcPlus4_w;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] rs);
    if (rs == 5'd0) return 32'h0;
    if (regWrite_w && rs == destinationReg_w) return exp_result();
    return mregs[rs];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
    mcnt = 64'h0;
  endtask

  always @(posedge clk) begin
    if (rst_n === 1'b1) begin
      if (regWrite_w && destinationReg_w != 5'd0) mregs[destinationReg_w] = exp_result();
      if (retire_w) mcnt = mcnt + 64'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("result_w", {32'h0, result_w}, {32'h0, exp_result()});
      check("rd1_d", {32'h0, rd1_d}, {32'h0, exp_rd(rs1_d)});
      check("rd2_d", {32'h0, rd2_d}, {32'h0, exp_rd(rs2_d)});
      check("instret", instret, mcnt);
      check("rd1_d narrow", {32'h0, rd1_s}, {32'h0, exp_rd(rs1_d)});
      check("instret narrow", {60'h0, instret_s}, {60'h0, mcnt[3:0]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] rd, input logic [1:0] src, input logic [31:0] val);
    regWrite_w = 1'b1; destinationReg_w = rd; resultSrc_w = src;
    aluResult_w = val; readData_w = val; pcPlus4_w = val;
    cyc();
    regWrite_w = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; regWrite_w = 1'b0; resultSrc_w = 2'b00;
    aluResult_w = '0; readData_w = '0; pcPlus4_w = '0;
    destinationReg_w = '0; retire_w = 1'b0; rs1_d = '0; rs2_d = '0;
    model_reset();
    repeat (2) cyc();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state on every address, both ports.
    for (int i = 0; i < 32; i++) begin
      rs1_d = 5'(i); rs2_d = 5'(31 - i);
      #1;
      check("reset rd1", {32'h0, rd1_d}, 64'h0);
      check("reset rd2", {32'h0, rd2_d}, 64'h0);
    end
    check("reset instret", instret, 64'h0);

    // Basic ALU write, visible the cycle after.
    write(5'd5, 2'b00, 32'hDEADBEEF);
    rs1_d = 5'd5; #1;
    check("x5 alu", {32'h0, rd1_d}, 64'hDEADBEEF);

    // Source select, with the other sources holding decoys.
    regWrite_w = 1'b1; destinationReg_w = 5'd7; resultSrc_w = 2'b01;
    aluResult_w = 32'h1111; readData_w = 32'h1234; pcPlus4_w = 32'h2222;
    cyc();
    destinationReg_w = 5'd8; resultSrc_w = 2'b10; pcPlus4_w = 32'h104;
    cyc();
    destinationReg_w = 5'd9; resultSrc_w = 2'b11;
    #1;
    check("result src11", {32'h0, result_w}, 64'h0);
    cyc();
    regWrite_w = 1'b0;
    rs1_d = 5'd7; rs2_d = 5'd8; #1;
    check("x7 load", {32'h0, rd1_d}, 64'h1234);
    check("x8 pc4", {32'h0, rd2_d}, 64'h104);
    rs1_d = 5'd9; #1;
    check("x9 reserved", {32'h0, rd1_d}, 64'h0);

    // x0 stays zero, even on the bypass path.
    rs1_d = 5'd0; rs2_d = 5'd0;
    regWrite_w = 1'b1; destinationReg_w = 5'd0; resultSrc_w = 2'b00; aluResult_w = 32'hFFFFFFFF;
    #1;
    check("x0 bypass rd1", {32'h0, rd1_d}, 64'h0);
    check("x0 bypass rd2", {32'h0, rd2_d}, 64'h0);
    cyc();
    regWrite_w = 1'b0; #1;
    check("x0 after", {32'h0, rd1_d}, 64'h0);

    // Dual-port bypass on a pending write to x3.
    rs1_d = 5'd3; rs2_d = 5'd3;
    regWrite_w = 1'b1; destinationReg_w = 5'd3; aluResult_w = 32'hA5A5A5A5;
    #1;
    check("bypass rd1", {32'h0, rd1_d}, 64'hA5A5A5A5);
    check("bypass rd2", {32'h0, rd2_d}, 64'hA5A5A5A5);
    cyc();
    regWrite_w = 1'b0; aluResult_w = 32'h0; #1;
    check("x3 stored", {32'h0, rd1_d}, 64'hA5A5A5A5);

    // Counter: 10 retires with writes toggling, then wrap the narrow copy.
    for (int i = 0; i < 10; i++) begin
      retire_w = 1'b1; regWrite_w = i[0];
      destinationReg_w = 5'(10 + i); aluResult_w = $urandom; resultSrc_w = 2'b00;
      cyc();
    end
    retire_w = 1'b0; regWrite_w = 1'b0; #1;
    check("instret 10", instret, 64'd10);
    retire_w = 1'b1;
    repeat (5) cyc();
    retire_w = 1'b0; #1;
    check("narrow all-ones", {60'h0, instret_s}, 64'hF);
    retire_w = 1'b1; cyc(); retire_w = 1'b0; #1;
    check("narrow wrap", {60'h0, instret_s}, 64'h0);
    check("instret 16", instret, 64'd16);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      regWrite_w = 1'($urandom); resultSrc_w = 2'($urandom);
      aluResult_w = $urandom; readData_w = $urandom; pcPlus4_w = $urandom;
      destinationReg_w = 5'($urandom); retire_w = 1'($urandom);
      if ($urandom_range(0, 3) == 0) rs1_d = destinationReg_w; else rs1_d = 5'($urandom);
      if ($urandom_range(0, 3) == 0) rs2_d = destinationReg_w; else rs2_d = 5'($urandom);
      cyc();
    end
    regWrite_w = 1'b0; retire_w = 1'b0;

    // Asynchronous reset between edges after writing x1..x4.
    for (int i = 1; i <= 4; i++) write(5'(i), 2'b00, 32'h100 + 32'(i));
    rs1_d = 5'd4; #1;
    check("x4 before reset", {32'h0, rd1_d}, 64'h104);
    #2;
    rst_n = 1'b0; model_reset();
    #1;
    for (int i = 1; i <= 4; i++) begin
      rs1_d = 5'(i); rs2_d = 5'(i); #1;
      check("async clear rd1", {32'h0, rd1_d}, 64'h0);
      check("async clear rd2", {32'h0, rd2_d}, 64'h0);
    end
    check("async clear instret", instret, 64'h0);
    regWrite_w = 1'b1; destinationReg_w = 5'd2; resultSrc_w = 2'b00; aluResult_w = 32'h55;
    retire_w = 1'b1;
    cyc();
    regWrite_w = 1'b0; retire_w = 1'b0; rs1_d = 5'd2; #1;
    check("write in reset", {32'h0, rd1_d}, 64'h0);
    check("count in reset", instret, 64'h0);
    cyc();
    rst_n = 1'b1; #1;
    check("x2 after reset", {32'h0, rd1_d}, 64'h0);
    write(5'd2, 2'b01, 32'h77);
    #1;
    check("first write after reset", {32'h0, rd1_d}, 64'h77);
    cyc();

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
